// File: rtl/obs_align_monitor.sv
// rtl/obs_align_monitor.sv - aligns source/target non-stuttered observations and keeps sticky verdicts
module obs_align_monitor #(
    parameter int W     = 1,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [W-1:0]             public_out_src,
    input  logic                     st_src,
    input  logic [W-1:0]             public_out_tar,
    input  logic                     st_tar,
    output logic                     mismatch,
    output logic                     overflow,
    output logic                     aligned,
    output logic                     lead_tar,
    output logic [$clog2(DEPTH):0]   pending,
    output logic [CNT_W-1:0]         matched
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int PEND_W = PTR_W + 1;
    localparam logic [PEND_W-1:0] FULL = PEND_W'(DEPTH);

    logic [W-1:0]       mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PEND_W-1:0]  pend_q, pend_d;
    logic               lead_q, lead_d;
    logic               mis_q, mis_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   matched_q, matched_d;

    logic               s, t;
    logic               err;
    logic [W-1:0]       head;
    logic [W-1:0]       step_val;
    logic               mem_we;
    logic [W-1:0]       mem_wdata;
    logic               cmp_en;
    logic [W-1:0]       cmp_a, cmp_b;

    assign s        = !st_src;
    assign t        = !st_tar;
    assign err      = mis_q || ovf_q;
    assign head     = mem_q[rd_ptr_q];
    assign step_val = t ? public_out_tar : public_out_src;

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        pend_d    = pend_q;
        lead_d    = lead_q;
        mis_d     = mis_q;
        ovf_d     = ovf_q;
        matched_d = matched_q;
        mem_we    = 1'b0;
        mem_wdata = public_out_src;
        cmp_en    = 1'b0;
        cmp_a     = public_out_src;
        cmp_b     = public_out_tar;

        if (en && !err) begin
            if (s && t) begin
                cmp_en = 1'b1;
                // Both step while one side leads: follower pops the head, leader refills the tail
                if (pend_q != '0) begin
                    cmp_a     = lead_q ? public_out_src : public_out_tar;
                    cmp_b     = head;
                    rd_ptr_d  = rd_ptr_q + PTR_W'(1);
                    mem_we    = 1'b1;
                    mem_wdata = lead_q ? public_out_tar : public_out_src;
                    wr_ptr_d  = wr_ptr_q + PTR_W'(1);
                end
            end else if (s ^ t) begin
                if (pend_q == '0 || lead_q == t) begin
                    if (pend_q != FULL) begin
                        mem_we    = 1'b1;
                        mem_wdata = step_val;
                        wr_ptr_d  = wr_ptr_q + PTR_W'(1);
                        pend_d    = pend_q + PEND_W'(1);
                        lead_d    = t;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else begin
                    cmp_en   = 1'b1;
                    cmp_a    = step_val;
                    cmp_b    = head;
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    pend_d   = pend_q - PEND_W'(1);
                end
            end

            if (cmp_en) begin
                if (cmp_a == cmp_b) begin
                    if (matched_q != '1) begin
                        matched_d = matched_q + CNT_W'(1);
                    end
                end else begin
                    mis_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            pend_q    <= '0;
            lead_q    <= 1'b0;
            mis_q     <= 1'b0;
            ovf_q     <= 1'b0;
            matched_q <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            pend_q    <= pend_d;
            lead_q    <= lead_d;
            mis_q     <= mis_d;
            ovf_q     <= ovf_d;
            matched_q <= matched_d;
        end
    end

    // Buffer contents need no reset; pending/pointers define what is live
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= mem_wdata;
        end
    end

    assign mismatch = mis_q;
    assign overflow = ovf_q;
    assign aligned  = (pend_q == '0) && !mis_q && !ovf_q;
    assign lead_tar = lead_q;
    assign pending  = pend_q;
    assign matched  = matched_q;

endmodule

// File: tb/tb_obs_align_monitor.sv
// tb/tb_obs_align_monitor.sv - scoreboard bench for obs_align_monitor with directed vectors
module tb_obs_align_monitor;

    localparam int W     = 2;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en  = 1'b0;
    logic [W-1:0]     public_out_src = '0;
    logic             st_src = 1'b1;
    logic [W-1:0]     public_out_tar = '0;
    logic             st_tar = 1'b1;
    logic             mismatch;
    logic             overflow;
    logic             aligned;
    logic             lead_tar;
    logic [2:0]       pending;
    logic [CNT_W-1:0] matched;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] id;
        logic        care;
        logic [14:0] v;
    } exp_t;

    exp_t exp_q[$];

    obs_align_monitor #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .public_out_src (public_out_src),
        .st_src         (st_src),
        .public_out_tar (public_out_tar),
        .st_tar         (st_tar),
        .mismatch       (mismatch),
        .overflow       (overflow),
        .aligned        (aligned),
        .lead_tar       (lead_tar),
        .pending        (pending),
        .matched        (matched)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] pack_exp(input logic mis, input logic ovf,
                                             input logic [2:0] pend, input logic lead,
                                             input logic [7:0] m);
        logic al;
        al = (pend == 3'd0) && !mis && !ovf;
        return {mis, ovf, al, lead, pend, m};
    endfunction

    task automatic check(input int id, input logic [14:0] e, input logic care);
        logic [14:0] act;
        logic [14:0] msk;
        act = {mismatch, overflow, aligned, lead_tar, pending, matched};
        msk = care ? 15'h7fff : 15'h77ff;
        checks++;
        if ((act & msk) !== (e & msk)) begin
            failures++;
            $display("FAIL step%0d {mis,ovf,al,lead,pend,matched} got=%h want=%h mask=%h",
                     id, act, e, msk);
        end
    endtask

    // Monitor: each clock, the DUT presents a new verdict snapshot to be scored
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(int'(e.id), e.v, e.care);
        end
    end

    task automatic step(input int id, input logic e_en,
                        input logic sts, input logic [W-1:0] vs,
                        input logic stt, input logic [W-1:0] vt,
                        input logic mis, input logic ovf, input logic [2:0] pend,
                        input logic lead, input logic care, input logic [7:0] m);
        exp_t e;
        @(negedge clk);
        en             = e_en;
        st_src         = sts;
        public_out_src = vs;
        st_tar         = stt;
        public_out_tar = vt;
        e.id   = 32'(id);
        e.care = care;
        e.v    = pack_exp(mis, ovf, pend, lead, m);
        exp_q.push_back(e);
    endtask

    task automatic async_reset(input int id);
        @(negedge clk);
        en = 1'b0;
        #2 rst = 1'b1;
        #1 check(id, pack_exp(1'b0, 1'b0, 3'd0, 1'b0, 8'd0), 1'b1);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int budget;
        #1 check(0, pack_exp(1'b0, 1'b0, 3'd0, 1'b0, 8'd0), 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // lockstep
        step(10, 1, 0, 2'd1, 0, 2'd1, 0, 0, 3'd0, 0, 0, 8'd1);
        step(11, 1, 0, 2'd2, 0, 2'd2, 0, 0, 3'd0, 0, 0, 8'd2);
        step(12, 1, 0, 2'd3, 0, 2'd3, 0, 0, 3'd0, 0, 0, 8'd3);
        // source leads, target catches up
        step(20, 1, 0, 2'd1, 1, 2'd0, 0, 0, 3'd1, 0, 1, 8'd3);
        step(21, 1, 0, 2'd2, 1, 2'd3, 0, 0, 3'd2, 0, 1, 8'd3);
        step(22, 1, 1, 2'd0, 0, 2'd1, 0, 0, 3'd1, 0, 1, 8'd4);
        step(23, 1, 1, 2'd3, 0, 2'd2, 0, 0, 3'd0, 0, 0, 8'd5);
        // en=0 holds everything
        step(30, 0, 0, 2'd1, 0, 2'd2, 0, 0, 3'd0, 0, 0, 8'd5);
        step(31, 0, 0, 2'd3, 1, 2'd0, 0, 0, 3'd0, 0, 0, 8'd5);
        // target fills to DEPTH, then full swaps, then source drains through wrapped slots
        step(40, 1, 1, 2'd0, 0, 2'd0, 0, 0, 3'd1, 1, 1, 8'd5);
        step(41, 1, 1, 2'd0, 0, 2'd1, 0, 0, 3'd2, 1, 1, 8'd5);
        step(42, 1, 1, 2'd0, 0, 2'd2, 0, 0, 3'd3, 1, 1, 8'd5);
        step(43, 1, 1, 2'd0, 0, 2'd3, 0, 0, 3'd4, 1, 1, 8'd5);
        step(44, 1, 0, 2'd0, 0, 2'd2, 0, 0, 3'd4, 1, 1, 8'd6);
        step(45, 1, 0, 2'd1, 0, 2'd1, 0, 0, 3'd4, 1, 1, 8'd7);
        step(46, 1, 0, 2'd2, 1, 2'd0, 0, 0, 3'd3, 1, 1, 8'd8);
        step(47, 1, 0, 2'd3, 1, 2'd0, 0, 0, 3'd2, 1, 1, 8'd9);
        step(48, 1, 0, 2'd2, 1, 2'd0, 0, 0, 3'd1, 1, 1, 8'd10);
        step(49, 1, 0, 2'd1, 1, 2'd0, 0, 0, 3'd0, 1, 0, 8'd11);
        // overflow on the fifth unanswered target step, then frozen
        step(50, 1, 1, 2'd0, 0, 2'd1, 0, 0, 3'd1, 1, 1, 8'd11);
        step(51, 1, 1, 2'd0, 0, 2'd1, 0, 0, 3'd2, 1, 1, 8'd11);
        step(52, 1, 1, 2'd0, 0, 2'd1, 0, 0, 3'd3, 1, 1, 8'd11);
        step(53, 1, 1, 2'd0, 0, 2'd1, 0, 0, 3'd4, 1, 1, 8'd11);
        step(54, 1, 1, 2'd0, 0, 2'd1, 0, 1, 3'd4, 1, 1, 8'd11);
        step(55, 1, 0, 2'd1, 0, 2'd1, 0, 1, 3'd4, 1, 1, 8'd11);
        step(56, 1, 0, 2'd0, 1, 2'd0, 0, 1, 3'd4, 1, 1, 8'd11);
        async_reset(60);
        // single-sided mismatch, then frozen
        step(61, 1, 0, 2'd3, 1, 2'd0, 0, 0, 3'd1, 0, 1, 8'd0);
        step(62, 1, 1, 2'd0, 0, 2'd2, 1, 0, 3'd0, 0, 0, 8'd0);
        step(63, 1, 0, 2'd1, 0, 2'd1, 1, 0, 3'd0, 0, 0, 8'd0);
        step(64, 1, 1, 2'd0, 0, 2'd2, 1, 0, 3'd0, 0, 0, 8'd0);
        async_reset(65);
        // pending=3 and mismatch via a swap, then asynchronous reset
        step(70, 1, 0, 2'd1, 1, 2'd0, 0, 0, 3'd1, 0, 1, 8'd0);
        step(71, 1, 0, 2'd2, 1, 2'd0, 0, 0, 3'd2, 0, 1, 8'd0);
        step(72, 1, 0, 2'd3, 1, 2'd0, 0, 0, 3'd3, 0, 1, 8'd0);
        step(73, 1, 0, 2'd2, 0, 2'd0, 1, 0, 3'd3, 0, 1, 8'd0);
        async_reset(74);
        step(75, 0, 0, 2'd1, 1, 2'd2, 0, 0, 3'd0, 0, 1, 8'd0);
        step(76, 0, 0, 2'd3, 0, 2'd0, 0, 0, 3'd0, 0, 1, 8'd0);
        step(77, 1, 0, 2'd2, 0, 2'd2, 0, 0, 3'd0, 0, 0, 8'd1);
        @(negedge clk);
        en = 1'b0;

        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending_expectations=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/obs_align_monitor.md
Name: obs_align_monitor

Overview:
- Consumes the observation streams (public output plus stutter flag) of the source and target codeblocks.
- Decides on-line whether the non-stuttered public-output sequences agree.
- It is the reader end of the codeblock output interface: codeblocks emit (public_out, st) per step; this block aligns and compares them.
- Sits beside the two codeblock instances in the system wrapper and drives sticky verdict bits to the model-checking harness.

Parameters:
- W, 1, width of the public output of each codeblock.
- DEPTH, 4, maximum number of non-stuttered observations one side may run ahead of the other; power of two, at least 2.
- CNT_W, 8, width of the matched-observation counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  step-valid qualifier; the wrapper drives it with its not_first flag. When it is 0, no state changes.
- public_out_src  input  W  source codeblock public output.
- st_src  input  1  source stutter flag. When it is 1, the source observation is not consumed.
- public_out_tar  input  W  target codeblock public output.
- st_tar  input  1  target stutter flag.
- mismatch  output  1  sticky: an aligned observation pair differed.
- overflow  output  1  sticky: the leading side exceeded DEPTH pending observations.
- aligned  output  1  1 when no observations are pending and no error flag is set.
- lead_tar  output  1  owner of the pending entries: 1 means target ahead, 0 means source ahead. Valid only when pending is nonzero.
- pending  output  clog2(DEPTH)+1  number of buffered leader observations.
- matched  output  CNT_W  count of successful pair comparisons; saturates at all-ones.

Behaviour:
- Reset (asynchronous, rst=1) clears all outputs: mismatch=0, overflow=0, aligned=1, lead_tar=0, pending=0, matched=0. It also clears the ring-buffer read and write pointers. Buffer contents are don't-care. Reset mid-run discards all pending entries immediately.
- Storage: ring buffer of DEPTH x W with rd_ptr and wr_ptr, both wrapping modulo DEPTH, plus pending count and owner bit lead_tar.
- Per rising edge with en=1 and no error set, define s = !st_src and t = !st_tar.
- s=0 and t=0: no change.
- s=1 and t=1 with pending=0: compare public_out_src against public_out_tar. Equal: matched+1. Differ: set mismatch.
- s=1 and t=1 with pending>0:
  - The follower's value (source if lead_tar=1, else target) is compared against buf[rd_ptr], and rd_ptr advances.
  - The leader's value is written at wr_ptr, and wr_ptr advances.
  - pending is unchanged; this is legal even when pending=DEPTH.
  - Compare result updates matched or mismatch as in the pending=0 case.
- Exactly one side steps, and either pending=0 or that side is the owner:
  - pending<DEPTH: push its value, pending+1, lead_tar = (stepping side is target).
  - pending=DEPTH: set overflow; the value is dropped and no other state changes.
- Exactly one side steps and the other side is the owner (pending>0): compare its value against the head, pop, pending-1. lead_tar keeps its value (don't-care once pending=0).
- Error freeze: once mismatch or overflow is 1, buffer, pointers, pending and matched hold until reset. Both flags may become set in the same cycle only if one side overflows while... no such case exists, since one event occurs per edge; both flags therefore never set in the same cycle.
- aligned is combinational: (pending==0) and !mismatch and !overflow.
- Latency: verdict flags and counters reflect the inputs of the preceding enabled edge; one-cycle latency, no combinational input-to-flag path.
- en=0 with stutter flags at any value: full hold.

Test Plan:
- Lockstep: W=2. Both sides step 3 cycles with values 1,2,3 each side, no stutter -> matched=3, pending=0, aligned=1, mismatch=0.
- Source leads: source emits 1,2 while st_tar=1; then target emits 1,2 while st_src=1 -> pending goes 1,2,1,0; lead_tar=0 during lead; matched=2; no error.
- Mismatch: source emits 3 alone, then target emits 2 alone -> mismatch=1 the next cycle. Further matching input leaves matched and pending frozen.
- Overflow: target steps 5 times with st_src=1, DEPTH=4 -> pending=4 after 4 steps; overflow=1 after the 5th; aligned=0.
- Full swap: pending=4 with target ahead; both step, source value equal to head -> pending stays 4, matched+1, overflow stays 0. Also check wr_ptr wrap.
- Async reset: assert rst mid-edge-window with pending=3 and mismatch=1 -> all outputs return to reset values immediately, without waiting for a clk edge. en=0 cycles afterwards cause no change.
